// File: rtl/demux_scan_ctrl_pkg.sv
// Shared types and sizes for the demux scan controller.
// State encoding is fixed so status decoders elsewhere can rely on it.
package demux_pkg;

  localparam int NUM_CH  = 8;
  localparam int SEL_W   = 3;
  localparam int DWELL_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/demux_scan_ctrl_if.sv
// Control/status bundle between the scan sequencer and its driver.
// The slave side is the sequencer; the master side drives start/stop.
interface demux_scan_ctrl_if;
  import demux_pkg::*;

  logic               start;
  logic               stop;
  logic               mode_cont;
  logic [DWELL_W-1:0] dwell;
  logic [NUM_CH-1:0]  ch_mask;
  logic               data_in;
  logic [SEL_W-1:0]   sel;
  logic               in;
  logic               busy;
  logic               ch_strobe;
  logic               done;

  modport master (
    output start, stop, mode_cont,
    output dwell, ch_mask, data_in,
    input  sel, in, busy,
    input  ch_strobe, done
  );

  modport slave (
    input  start, stop, mode_cont,
    input  dwell, ch_mask, data_in,
    output sel, in, busy,
    output ch_strobe, done
  );

endinterface

// File: rtl/demux_scan_ctrl_next_ch.sv
// Rotating priority encoder: next enabled channel above cur_i,
// wrapping to the lowest enabled channel when none is above.
module demux_next_ch
  import demux_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  cur_i,
  output logic [SEL_W-1:0]  nxt_o,
  output logic              wrap_o,
  output logic [SEL_W-1:0]  low_o
);

  always_comb begin
    low_o  = '0;
    nxt_o  = '0;
    wrap_o = 1'b1;
    // descending walk leaves the smallest match
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i]) low_o = SEL_W'(i);
    end
    nxt_o = low_o;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (SEL_W'(i) > cur_i)) begin
        nxt_o  = SEL_W'(i);
        wrap_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/demux_scan_ctrl.sv
// Scan sequencer for the 1:8 demux: steps sel through enabled
// channels with a programmable dwell and forwards serial data.
module demux_scan_ctrl
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  demux_scan_ctrl_if.slave  bus
);

  state_e             state_q;
  logic [NUM_CH-1:0]  mask_q;
  logic               cont_q;
  logic [DWELL_W-1:0] last_q;
  logic [DWELL_W-1:0] last_d;
  logic [DWELL_W-1:0] cnt_q;
  logic [SEL_W-1:0]   sel_q;
  logic               in_q;
  logic               busy_q;
  logic               strobe_q;
  logic               done_q;

  logic [NUM_CH-1:0]  enc_mask;
  logic [SEL_W-1:0]   nxt_ch;
  logic [SEL_W-1:0]   low_ch;
  logic               wrap;
  logic               dwell_end;
  logic               go;

  // Encoder looks at the live mask only while idle
  assign enc_mask  = (state_q == IDLE) ? bus.ch_mask : mask_q;
  assign last_d    = (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;
  assign dwell_end = (cnt_q == last_q);
  assign go        = bus.start & ~bus.stop & (|bus.ch_mask);

  demux_next_ch u_next (
    .mask_i (enc_mask),
    .cur_i  (sel_q),
    .nxt_o  (nxt_ch),
    .wrap_o (wrap),
    .low_o  (low_ch)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      cont_q   <= 1'b0;
      last_q   <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      in_q     <= 1'b0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          in_q <= 1'b0;
          if (go) begin
            state_q  <= SCAN;
            busy_q   <= 1'b1;
            sel_q    <= low_ch;
            strobe_q <= 1'b1;
            cnt_q    <= '0;
            last_q   <= last_d;
            mask_q   <= bus.ch_mask;
            cont_q   <= bus.mode_cont;
          end
        end
        SCAN: begin
          if (bus.stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            sel_q   <= '0;
            in_q    <= 1'b0;
            cnt_q   <= '0;
          end else if (!dwell_end) begin
            cnt_q <= cnt_q + 1'b1;
            in_q  <= bus.data_in;
          end else begin
            cnt_q <= '0;
            in_q  <= bus.data_in;
            if (!wrap) begin
              sel_q    <= nxt_ch;
              strobe_q <= 1'b1;
            end else begin
              done_q <= 1'b1;
              if (cont_q) begin
                sel_q    <= low_ch;
                strobe_q <= 1'b1;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                sel_q   <= '0;
                in_q    <= 1'b0;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.in        = in_q;
  assign bus.busy      = busy_q;
  assign bus.ch_strobe = strobe_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Directed bench for demux_scan_ctrl: scans, stop, ignored starts,
// data path and reset, with hand-computed expectations.
module tb_demux_scan_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  demux_scan_ctrl_if bus ();

  demux_scan_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [6:0] obs;
    rst = 1'b1;
    tick;
    tick;
    obs = {bus.busy, bus.sel, bus.ch_strobe, bus.done, bus.in};
    n_cmp++;
    if (obs !== 7'b0) begin
      n_bad++;
      $display("FAIL reset got=%b exp=%b", obs, 7'b0);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_full_scan;
    logic [5:0] obs;
    logic [5:0] exp;
    bus.ch_mask   = 8'hFF;
    bus.dwell     = 8'd2;
    bus.mode_cont = 1'b0;
    bus.start     = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      exp = {1'b1, 3'(c / 2), (c % 2 == 0), 1'b0};
      obs = {bus.busy, bus.sel, bus.ch_strobe, bus.done};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL full_scan c=%0d got=%b exp=%b", c, obs, exp);
      end
      tick;
    end
    obs = {bus.busy, bus.sel, bus.ch_strobe, bus.done};
    n_cmp++;
    if (obs !== 6'b0_000_0_1) begin
      n_bad++;
      $display("FAIL full_scan_done got=%b exp=%b", obs, 6'b0_000_0_1);
    end
    tick;
    obs = {bus.busy, bus.sel, bus.ch_strobe, bus.done};
    n_cmp++;
    if (obs !== 6'b0) begin
      n_bad++;
      $display("FAIL full_scan_idle got=%b exp=%b", obs, 6'b0);
    end
  endtask

  task automatic test_sparse_zero_dwell;
    logic [5:0] obs;
    logic [5:0] v [4];
    v = '{6'b1_010_1_0, 6'b1_101_1_0, 6'b1_111_1_0, 6'b0_000_0_1};
    bus.ch_mask   = 8'b1010_0100;
    bus.dwell     = 8'd0;
    bus.mode_cont = 1'b0;
    bus.start     = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      obs = {bus.busy, bus.sel, bus.ch_strobe, bus.done};
      n_cmp++;
      if (obs !== v[c]) begin
        n_bad++;
        $display("FAIL sparse c=%0d got=%b exp=%b", c, obs, v[c]);
      end
      tick;
    end
  endtask

  task automatic test_cont_stop;
    logic [6:0] obs;
    logic [5:0] o6;
    logic [5:0] v [4];
    v = '{6'b1_000_1_0, 6'b1_111_1_0, 6'b1_000_1_1, 6'b1_111_1_0};
    bus.ch_mask   = 8'h81;
    bus.dwell     = 8'd1;
    bus.mode_cont = 1'b1;
    bus.start     = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      o6 = {bus.busy, bus.sel, bus.ch_strobe, bus.done};
      n_cmp++;
      if (o6 !== v[c]) begin
        n_bad++;
        $display("FAIL cont c=%0d got=%b exp=%b", c, o6, v[c]);
      end
      if (c < 3) tick;
    end
    // stop on the last dwell cycle of ch7: no done allowed
    bus.data_in = 1'b1;
    bus.stop    = 1'b1;
    tick;
    bus.stop      = 1'b0;
    bus.mode_cont = 1'b0;
    obs = {bus.busy, bus.sel, bus.ch_strobe, bus.done, bus.in};
    n_cmp++;
    if (obs !== 7'b0) begin
      n_bad++;
      $display("FAIL cont_stop got=%b exp=%b", obs, 7'b0);
    end
    tick;
    obs = {bus.busy, bus.sel, bus.ch_strobe, bus.done, bus.in};
    n_cmp++;
    if (obs !== 7'b0) begin
      n_bad++;
      $display("FAIL cont_stop_after got=%b exp=%b", obs, 7'b0);
    end
    bus.data_in = 1'b0;
  endtask

  task automatic test_ignored_start;
    logic [5:0] obs;
    bus.ch_mask = 8'hFF;
    bus.dwell   = 8'd4;
    bus.start   = 1'b1;
    bus.stop    = 1'b1;
    tick;
    bus.stop = 1'b0;
    bus.start = 1'b0;
    obs = {bus.busy, bus.sel, bus.ch_strobe, bus.done};
    n_cmp++;
    if (obs !== 6'b0) begin
      n_bad++;
      $display("FAIL start_with_stop got=%b exp=%b", obs, 6'b0);
    end
    bus.ch_mask = 8'h00;
    bus.start   = 1'b1;
    tick;
    bus.start = 1'b0;
    obs = {bus.busy, bus.sel, bus.ch_strobe, bus.done};
    n_cmp++;
    if (obs !== 6'b0) begin
      n_bad++;
      $display("FAIL start_mask0 got=%b exp=%b", obs, 6'b0);
    end
    bus.ch_mask = 8'hFF;
    bus.start   = 1'b1;
    tick;
    obs = {bus.busy, bus.sel, bus.ch_strobe, bus.done};
    n_cmp++;
    if (obs !== 6'b1_000_1_0) begin
      n_bad++;
      $display("FAIL busy_start_c0 got=%b exp=%b", obs, 6'b1_000_1_0);
    end
    for (int c = 1; c < 4; c++) begin
      tick;
      obs = {bus.busy, bus.sel, bus.ch_strobe, bus.done};
      n_cmp++;
      if (obs !== 6'b1_000_0_0) begin
        n_bad++;
        $display("FAIL busy_start c=%0d got=%b exp=%b", c, obs, 6'b1_000_0_0);
      end
    end
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    tick;
    bus.stop = 1'b0;
  endtask

  task automatic test_max_dwell;
    int cnt;
    logic [1:0] obs;
    bus.ch_mask   = 8'h01;
    bus.dwell     = 8'd255;
    bus.mode_cont = 1'b0;
    bus.start     = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.dwell = 8'd1;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 600) begin
      cnt++;
      tick;
    end
    n_cmp++;
    if (cnt !== 255) begin
      n_bad++;
      $display("FAIL max_dwell_len got=%0d exp=%0d", cnt, 255);
    end
    obs = {bus.busy, bus.done};
    n_cmp++;
    if (obs !== 2'b01) begin
      n_bad++;
      $display("FAIL max_dwell_done got=%b exp=%b", obs, 2'b01);
    end
    tick;
  endtask

  task automatic test_data;
    logic [7:0] pat;
    logic [2:0] obs;
    pat           = 8'b1011_0010;
    bus.data_in   = 1'b1;
    bus.ch_mask   = 8'hFF;
    bus.dwell     = 8'd1;
    bus.mode_cont = 1'b0;
    bus.start     = 1'b1;
    tick;
    bus.start = 1'b0;
    n_cmp++;
    if (bus.in !== 1'b0) begin
      n_bad++;
      $display("FAIL data_c0 got=%b exp=%b", bus.in, 1'b0);
    end
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        n_cmp++;
        if (bus.in !== pat[c-1]) begin
          n_bad++;
          $display("FAIL data c=%0d got=%b exp=%b", c, bus.in, pat[c-1]);
        end
      end
      bus.data_in = pat[c];
      tick;
    end
    bus.data_in = 1'b1;
    obs = {bus.busy, bus.done, bus.in};
    n_cmp++;
    if (obs !== 3'b010) begin
      n_bad++;
      $display("FAIL data_end got=%b exp=%b", obs, 3'b010);
    end
    tick;
    n_cmp++;
    if (bus.in !== 1'b0) begin
      n_bad++;
      $display("FAIL data_idle got=%b exp=%b", bus.in, 1'b0);
    end
  endtask

  task automatic test_reset_mid_scan;
    logic [6:0] obs;
    bus.ch_mask   = 8'hFF;
    bus.dwell     = 8'd2;
    bus.mode_cont = 1'b1;
    bus.data_in   = 1'b1;
    bus.start     = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    obs = {bus.busy, bus.sel, bus.ch_strobe, bus.done, bus.in};
    n_cmp++;
    if (obs !== 7'b0) begin
      n_bad++;
      $display("FAIL rst_mid got=%b exp=%b", obs, 7'b0);
    end
    rst = 1'b0;
    bus.mode_cont = 1'b0;
    tick;
    obs = {bus.busy, bus.sel, bus.ch_strobe, bus.done, bus.in};
    n_cmp++;
    if (obs !== 7'b0) begin
      n_bad++;
      $display("FAIL rst_after got=%b exp=%b", obs, 7'b0);
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.mode_cont = 1'b0;
    bus.dwell     = '0;
    bus.ch_mask   = '0;
    bus.data_in   = 1'b0;
    test_reset;
    test_full_scan;
    test_sparse_zero_dwell;
    test_cont_stop;
    test_ignored_start;
    test_max_dwell;
    test_data;
    test_reset_mid_scan;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
